// File: rtl/gate_test_pkg.sv
// rtl/gate_test_pkg.sv - gate codes, valid-code list, FSM states and stim width for the gate self-test
package gate_test_pkg;

  localparam int STIM_W    = 5;
  localparam int NUM_CODES = 13;

  localparam logic [3:0] GC_AND      = 4'd0;
  localparam logic [3:0] GC_OR       = 4'd1;
  localparam logic [3:0] GC_NOT      = 4'd2;
  localparam logic [3:0] GC_NAND     = 4'd3;
  localparam logic [3:0] GC_NOR      = 4'd4;
  localparam logic [3:0] GC_XOR      = 4'd5;
  localparam logic [3:0] GC_XNOR     = 4'd6;
  localparam logic [3:0] GC_MUX      = 4'd7;
  localparam logic [3:0] GC_DMUX     = 4'd8;
  localparam logic [3:0] GC_MUX16    = 4'd9;
  localparam logic [3:0] GC_MUX4WAY  = 4'd10;
  localparam logic [3:0] GC_DMUX4WAY = 4'd13;
  localparam logic [3:0] GC_DMUX8WAY = 4'd14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DWELL,
    S_ADVANCE,
    S_DONE
  } state_t;

  // Maps the sweep index onto the populated gate codes; 11, 12 and 15 are holes in the bank.
  function automatic logic [3:0] valid_code(input logic [3:0] idx);
    case (idx)
      4'd0:    return GC_AND;
      4'd1:    return GC_OR;
      4'd2:    return GC_NOT;
      4'd3:    return GC_NAND;
      4'd4:    return GC_NOR;
      4'd5:    return GC_XOR;
      4'd6:    return GC_XNOR;
      4'd7:    return GC_MUX;
      4'd8:    return GC_DMUX;
      4'd9:    return GC_MUX16;
      4'd10:   return GC_MUX4WAY;
      4'd11:   return GC_DMUX4WAY;
      4'd12:   return GC_DMUX8WAY;
      default: return GC_AND;
    endcase
  endfunction

endpackage

// File: rtl/gate_test_sequencer_if.sv
// rtl/gate_test_sequencer_if.sv - gate select / stimulus / result bus between sequencer and gate bank
interface gate_test_sequencer_if;
  import gate_test_pkg::*;

  logic [3:0]        gate_sel;
  logic [STIM_W-1:0] stim;
  logic [7:0]        result_in;

  modport master (output gate_sel, output stim, input result_in);
  modport slave  (input gate_sel, input stim, output result_in);

endinterface

// File: rtl/gate_golden_model.sv
// rtl/gate_golden_model.sv - combinational expected output of the gate bank for a (gate_sel, stim) pair
module gate_golden_model
  import gate_test_pkg::*;
(
  input  logic [3:0]        gate_sel,
  input  logic [STIM_W-1:0] stim,
  output logic [7:0]        expected
);

  logic [7:0] bus_a;

  // One output per gate code; single-bit gates land on bit 0, the rest of the byte stays 0.
  always_comb begin
    expected = 8'h00;
    bus_a    = {2{stim[3:0]}};
    case (gate_sel)
      GC_AND:      expected[0] = stim[0] & stim[1];
      GC_OR:       expected[0] = stim[0] | stim[1];
      GC_NOT:      expected[0] = ~stim[0];
      GC_NAND:     expected[0] = ~(stim[0] & stim[1]);
      GC_NOR:      expected[0] = ~(stim[0] | stim[1]);
      GC_XOR:      expected[0] = stim[0] ^ stim[1];
      GC_XNOR:     expected[0] = ~(stim[0] ^ stim[1]);
      GC_MUX:      expected[0] = stim[2] ? stim[1] : stim[0];
      GC_DMUX:     expected[1:0] = stim[1] ? {stim[0], 1'b0} : {1'b0, stim[0]};
      GC_MUX16:    expected = stim[4] ? ~bus_a : bus_a;
      GC_MUX4WAY: begin
        case (stim[1:0])
          2'd0:    expected[0] = stim[2];
          2'd1:    expected[0] = stim[3];
          2'd2:    expected[0] = stim[4];
          default: expected[0] = ~stim[2];
        endcase
      end
      GC_DMUX4WAY: expected[3:0] = {3'b000, stim[0]} << stim[2:1];
      GC_DMUX8WAY: expected = {7'b0000000, stim[0]} << stim[3:1];
      default:     expected = 8'h00;
    endcase
  end

endmodule

// File: rtl/gate_test_sequencer.sv
// rtl/gate_test_sequencer.sv - gate bank self-test sweep; optional GATE_TEST_STOP_ON_FAIL_EN stops at first mismatch
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int DWELL_CYCLES  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  gate_test_sequencer_if.master        dp,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [8:0]                   fail_count,
  output logic [7:0]                   led
);

  // SETTLE lasts SETTLE_CYCLES-1 clocks; with the APPLY edge that gives SETTLE_CYCLES edges before CHECK samples.
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] DWELL_LOAD  = 16'(DWELL_CYCLES);
  localparam logic [3:0]  LAST_IDX    = 4'(NUM_CODES - 1);

  state_t            state, state_next;
  logic [3:0]        code_idx;
  logic [STIM_W-1:0] cur_stim;
  logic [15:0]       settle_cnt;
  logic [15:0]       dwell_cnt;
  logic [7:0]        expected;
  logic              mismatch;
  logic              pass_next;
  logic [6:0]        fail_count_7b;
`ifdef GATE_TEST_STOP_ON_FAIL_EN
  logic              stopped;
`endif

  gate_golden_model u_golden (
    .gate_sel (dp.gate_sel),
    .stim     (dp.stim),
    .expected (expected)
  );

  assign mismatch      = (dp.result_in != expected);
  assign pass_next     = (fail_count == 9'd0);
  assign fail_count_7b = (|fail_count[8:7]) ? 7'h7F : fail_count[6:0];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state decode; done is high for the single cycle spent in DONE.
  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      S_IDLE:   if (start) state_next = S_APPLY;
      S_APPLY:  state_next = S_SETTLE;
      S_SETTLE: if (settle_cnt <= 16'd1) state_next = S_CHECK;
      S_CHECK: begin
`ifdef GATE_TEST_STOP_ON_FAIL_EN
        if (mismatch)               state_next = S_DONE;
        else if (DWELL_CYCLES > 0)  state_next = S_DWELL;
        else                        state_next = S_ADVANCE;
`else
        if (DWELL_CYCLES > 0) state_next = S_DWELL;
        else                  state_next = S_ADVANCE;
`endif
      end
      S_DWELL:  if (dwell_cnt <= 16'd1) state_next = S_ADVANCE;
      S_ADVANCE: begin
        if (cur_stim != {STIM_W{1'b1}} || code_idx != LAST_IDX) state_next = S_APPLY;
        else                                                   state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  // Sweep indices, registered bus outputs, counters and the result/status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_idx    <= '0;
      cur_stim    <= '0;
      settle_cnt  <= '0;
      dwell_cnt   <= '0;
      dp.gate_sel <= '0;
      dp.stim     <= '0;
      busy        <= 1'b0;
      pass        <= 1'b0;
      fail_count  <= '0;
      led         <= '0;
`ifdef GATE_TEST_STOP_ON_FAIL_EN
      stopped     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            fail_count <= '0;
            code_idx   <= '0;
            cur_stim   <= '0;
            busy       <= 1'b1;
`ifdef GATE_TEST_STOP_ON_FAIL_EN
            stopped    <= 1'b0;
`endif
          end
        end
        S_APPLY: begin
          dp.gate_sel <= valid_code(code_idx);
          dp.stim     <= cur_stim;
          settle_cnt  <= SETTLE_LOAD;
        end
        S_SETTLE: settle_cnt <= settle_cnt - 16'd1;
        S_CHECK: begin
          if (mismatch && fail_count != 9'h1FF) fail_count <= fail_count + 9'd1;
          led       <= dp.result_in;
          dwell_cnt <= DWELL_LOAD;
`ifdef GATE_TEST_STOP_ON_FAIL_EN
          stopped   <= mismatch;
`endif
        end
        S_DWELL: dwell_cnt <= dwell_cnt - 16'd1;
        S_ADVANCE: begin
          if (cur_stim != {STIM_W{1'b1}}) begin
            cur_stim <= cur_stim + 1'b1;
          end else if (code_idx != LAST_IDX) begin
            cur_stim <= '0;
            code_idx <= code_idx + 4'd1;
          end
        end
        S_DONE: begin
          busy <= 1'b0;
          pass <= pass_next;
`ifdef GATE_TEST_STOP_ON_FAIL_EN
          // A stopped run keeps the failing result on the LEDs instead of the summary.
          if (!stopped) led <= {pass_next, fail_count_7b};
`else
          led  <= {pass_next, fail_count_7b};
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/gate_test_sequencer.md
Name: gate_test_sequencer

Overview:
- Self-test controller for the gate-selection datapath on the Mojo board.
- Replaces manual switch stepping: drives the gate select code and stimulus bits, waits for the registered LED path to settle, then samples the selected 8-bit result.
- Compares each result against a golden model, counts mismatches, and reports pass/fail on the LEDs.
- Sits between the top level's switch/LED logic and the gate bank; the top-level mux takes gate_sel/stim instead of sw1/sw2 while busy=1.

Parameters:
- SETTLE_CYCLES, 4, clocks between driving gate_sel/stim and sampling result_in (must be >=2; covers the LED register).
- DWELL_CYCLES, 0, extra clocks each vector's result is held on led for viewing; 0 = no dwell state.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a run when idle.
- result_in  in  8  selected gate output returned from the datapath.
- gate_sel  out  4  gate select code driven to the datapath mux.
- stim  out  5  stimulus: bits[3:0] are the switch-equivalent inputs, bit[4] is the auxiliary select (16-bit mux select).
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at run end.
- pass  out  1  sticky: 1 if the last run had zero mismatches.
- fail_count  out  9  mismatches in the last run, saturating at 511.
- led  out  8  display value.

Behaviour:
- Reset (rst_n=0 at posedge clk): state IDLE, gate_sel=0, stim=0, busy=0, done=0, pass=0, fail_count=0, led=0, all counters cleared. Reset mid-run aborts immediately with no done pulse.
- Vector order:
  - Outer loop over the valid code list from the package: 0,1,2,3,4,5,6,7,8,9,10,13,14 (13 codes).
  - Inner loop over stim 0..31.
  - Total 416 vectors. Codes 11, 12 and 15 are never driven.
- FSM:
  - IDLE: wait for start=1. Then clear fail_count, reset the code index and stim to 0, set busy=1, go to APPLY.
  - APPLY: drive gate_sel and stim, load the settle counter with SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE: decrement the counter; at 0 go to CHECK.
  - CHECK: compare result_in with expected(gate_sel, stim). On mismatch, fail_count += 1, saturating. led <= result_in. Go to DWELL if DWELL_CYCLES>0, else to ADVANCE.
  - DWELL: count DWELL_CYCLES, then go to ADVANCE.
  - ADVANCE:
    - stim < 31: stim += 1, go to APPLY.
    - stim = 31 and code index < 12: stim <= 0, code index += 1, go to APPLY.
    - Otherwise go to DONE.
  - DONE: pulse done for one cycle, busy <= 0, pass <= (fail_count==0), led <= {pass_next, fail_count saturated to 7 bits}, go to IDLE.
- start while busy is ignored. start in the same cycle as DONE is ignored; it is accepted the following cycle.
- Latency per vector: SETTLE_CYCLES+2 (+DWELL_CYCLES when nonzero). Run length with defaults: 416×6 + 2 cycles.
- gate_sel and stim are registered outputs and hold their values through SETTLE, CHECK and DWELL.
- led holds its last value while IDLE.

Optional Feature:
- Macro: GATE_TEST_STOP_ON_FAIL_EN.
- When defined: the first mismatch in CHECK goes directly to DONE with fail_count=1 and pass=0. gate_sel and stim freeze at the failing vector, and led holds the failing result_in (not the summary) until the next start.
- When undefined: the full sweep always runs.

Decomposition:
- Package gate_test_pkg holds:
  - The gate code constants (GC_AND=0 … GC_DMUX8WAY=14).
  - The valid-code list and its length (13).
  - The FSM state enum.
  - The stim width (5).
- Sub-module gate_golden_model is purely combinational: (gate_sel, stim) -> expected[7:0], mirroring the gate bank's bit mapping and zero-extending 1-bit gates to bit0. Verification reuses it as the scoreboard.

Test Plan:
1. Reset, then start, with result_in driven by a correct gate model -> done after 2498 cycles (defaults); pass=1, fail_count=0, led=8'h80.
2. Model with the AND gate stuck at 0 -> exactly the single AND vector with stim[1:0]=2'b11 mismatches, over 8 stim values -> fail_count=8, pass=0, led=8'h08.
3. result_in tied to 8'h00 -> fail_count equals the golden nonzero-vector count. Check that gate_sel never shows 11, 12 or 15.
4. Assert rst_n=0 at vector 200 -> next cycle busy=0, outputs at reset values, no done pulse. A new start runs a full 416-vector sweep.
5. Pulse start again while busy -> no restart; vector count stays 416. start on the DONE cycle is ignored.
6. With GATE_TEST_STOP_ON_FAIL_EN and the OR gate broken at stim=5'd1 -> done at the 34th vector; gate_sel=1, stim=1, fail_count=1.
